// File: rtl/status_pkg.sv
// Shared definitions for the status-display blocks: glyph codes and a
// constant clog2 helper usable in parameter expressions.
package status_pkg;

  localparam int CODE_W_DEF = 6;

  localparam logic [5:0] GLYPH_0     = 6'h00;
  localparam logic [5:0] GLYPH_1     = 6'h01;
  localparam logic [5:0] GLYPH_2     = 6'h02;
  localparam logic [5:0] GLYPH_3     = 6'h03;
  localparam logic [5:0] GLYPH_4     = 6'h04;
  localparam logic [5:0] GLYPH_5     = 6'h05;
  localparam logic [5:0] GLYPH_6     = 6'h06;
  localparam logic [5:0] GLYPH_7     = 6'h07;
  localparam logic [5:0] GLYPH_8     = 6'h08;
  localparam logic [5:0] GLYPH_9     = 6'h09;
  localparam logic [5:0] GLYPH_A     = 6'h0A;
  localparam logic [5:0] GLYPH_B     = 6'h0B;
  localparam logic [5:0] GLYPH_C     = 6'h0C;
  localparam logic [5:0] GLYPH_D     = 6'h0D;
  localparam logic [5:0] GLYPH_E     = 6'h0E;
  localparam logic [5:0] GLYPH_F     = 6'h0F;
  localparam logic [5:0] GLYPH_BLANK = 6'h10;
  localparam logic [5:0] GLYPH_DASH  = 6'h11;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/status_page_next.sv
// Round-robin finder: first valid page after cur_page, wrapping back to
// cur_page itself; holds cur_page when nothing is valid.
module status_page_next import status_pkg::*; #(
  parameter  int PAGES = 4,
  localparam int PW    = clog2(PAGES)
) (
  input  logic [PAGES-1:0] page_valid_i,
  input  logic [PW-1:0]    cur_page_i,
  output logic [PW-1:0]    next_page_o,
  output logic             any_valid_o
);

  logic [PW-1:0] idx;

  // Scan from the farthest offset inward so the nearest valid page wins.
  always_comb begin
    idx         = '0;
    next_page_o = cur_page_i;
    any_valid_o = 1'b0;
    for (int i = PAGES; i >= 1; i--) begin
      idx = PW'((int'(cur_page_i) + i) % PAGES);
      if (page_valid_i[idx]) begin
        next_page_o = idx;
        any_valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/status_pager.sv
// Multi-page 7-segment code driver: manual/timed page rotation, a timed
// overlay page triggered by watch-vector changes, and per-digit blinking.
module status_pager import status_pkg::*; #(
  parameter  int DIGITS    = 8,
  parameter  int CODE_W    = CODE_W_DEF,
  parameter  int PAGES     = 4,
  parameter  int WATCH_W   = 5,
  parameter  int HOLD_DIV  = 23,
  parameter  int DWELL_DIV = 26,
  parameter  int BLINK_DIV = 24,
  localparam int PW        = clog2(PAGES)
) (
  input  logic                           clk_peripheral,
  input  logic                           peripheral_reset,
  input  logic [PAGES*DIGITS*CODE_W-1:0] page_data,
  input  logic [PAGES-1:0]               page_valid,
  input  logic [DIGITS-1:0]              blink_mask,
  input  logic [DIGITS*CODE_W-1:0]       overlay_data,
  input  logic [WATCH_W-1:0]             watch,
  input  logic                           retrigger,
  input  logic                           auto_rotate,
  input  logic [PW-1:0]                  page_sel,
  input  logic                           next_page,
  output logic [DIGITS*CODE_W-1:0]       display,
  output logic [PW-1:0]                  cur_page,
  output logic                           overlay_active
);

  localparam int                PV    = 1 << PW;
  localparam logic [CODE_W-1:0] BLANK = CODE_W'(GLYPH_BLANK);

  logic [PAGES-1:0][DIGITS-1:0][CODE_W-1:0] pages;
  logic [DIGITS-1:0][CODE_W-1:0]            ovl, disp_d, disp_q;
  logic [PV-1:0]                            valid_ext;

  logic [WATCH_W-1:0]   watch_q;
  logic [HOLD_DIV-1:0]  hold_d, hold_q;
  logic [DWELL_DIV-1:0] dwell_d, dwell_q;
  logic [BLINK_DIV-1:0] blink_d, blink_q;
  logic [PW-1:0]        page_d, cur_page_q, nxt;
  logic                 any_valid, change, blink_phase;

  assign pages       = page_data;
  assign ovl         = overlay_data;
  // Padded so out-of-range selects read as invalid rather than X.
  assign valid_ext   = PV'(page_valid);
  assign change      = (watch != watch_q);
  assign blink_phase = blink_q[BLINK_DIV-1];

  assign overlay_active = |hold_q;
  assign cur_page       = cur_page_q;
  assign display        = disp_q;

  status_page_next #(.PAGES(PAGES)) u_next (
    .page_valid_i (page_valid),
    .cur_page_i   (cur_page_q),
    .next_page_o  (nxt),
    .any_valid_o  (any_valid)
  );

  always_comb begin
    hold_d  = hold_q;
    dwell_d = dwell_q;
    page_d  = cur_page_q;
    blink_d = blink_q + BLINK_DIV'(1);
    if (change || retrigger)  hold_d = '1;
    else if (overlay_active)  hold_d = hold_q - HOLD_DIV'(1);
    // next_page wins over both the dwell timer and page_sel.
    if (next_page) begin
      dwell_d = '0;
      if (any_valid) page_d = nxt;
    end else if (auto_rotate) begin
      if (!overlay_active) begin
        dwell_d = dwell_q + DWELL_DIV'(1);
        if (&dwell_q && any_valid) page_d = nxt;
      end
    end else if (valid_ext[page_sel]) begin
      page_d = page_sel;
    end
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_dig
    assign disp_d[g] = overlay_active ? ovl[g] :
                       (!valid_ext[cur_page_q] || (blink_mask[g] && blink_phase)) ? BLANK :
                       pages[cur_page_q][g];
  end

  always_ff @(posedge clk_peripheral) begin
    if (peripheral_reset) begin
      watch_q    <= watch;
      hold_q     <= '1;
      dwell_q    <= '0;
      blink_q    <= '0;
      cur_page_q <= '0;
      disp_q     <= {DIGITS{BLANK}};
    end else begin
      watch_q    <= watch;
      hold_q     <= hold_d;
      dwell_q    <= dwell_d;
      blink_q    <= blink_d;
      cur_page_q <= page_d;
      disp_q     <= disp_d;
    end
  end

endmodule

// File: tb/tb_status_pager.sv
// Bench for status_pager: directed phases plus random traffic, every cycle
// compared against a cycle-level behavioural model of the display rules.
module tb_status_pager;
  localparam int DIGITS = 4, CODE_W = 6, PAGES = 4, WATCH_W = 5;
  localparam int HOLD_DIV = 4, DWELL_DIV = 3, BLINK_DIV = 2, PW = 2;
  localparam int HOLD_MAX = (1 << HOLD_DIV) - 1;
  localparam int DWELL_MAX = (1 << DWELL_DIV) - 1;
  localparam int BLINK_N = 1 << BLINK_DIV;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                                     rst;
  logic [PAGES-1:0][DIGITS-1:0][CODE_W-1:0] pg;
  logic [PAGES-1:0]                         page_valid;
  logic [DIGITS-1:0]                        blink_mask;
  logic [DIGITS-1:0][CODE_W-1:0]            ovl_dat;
  logic [WATCH_W-1:0]                       watch;
  logic                                     retrigger, auto_rotate, next_page;
  logic [PW-1:0]                            page_sel;
  logic [DIGITS*CODE_W-1:0]                 display;
  logic [PW-1:0]                            cur_page;
  logic                                     overlay_active;

  status_pager #(
    .DIGITS(DIGITS), .CODE_W(CODE_W), .PAGES(PAGES), .WATCH_W(WATCH_W),
    .HOLD_DIV(HOLD_DIV), .DWELL_DIV(DWELL_DIV), .BLINK_DIV(BLINK_DIV)
  ) dut (
    .clk_peripheral(clk), .peripheral_reset(rst), .page_data(pg),
    .page_valid(page_valid), .blink_mask(blink_mask), .overlay_data(ovl_dat),
    .watch(watch), .retrigger(retrigger), .auto_rotate(auto_rotate),
    .page_sel(page_sel), .next_page(next_page), .display(display),
    .cur_page(cur_page), .overlay_active(overlay_active)
  );

  int checks = 0, errors = 0;

  int m_hold, m_dwell, m_blink, m_page;
  logic [WATCH_W-1:0]            m_wq;
  logic [DIGITS-1:0][CODE_W-1:0] m_disp, blank_all;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int next_valid(input int cur, input logic [PAGES-1:0] v);
    for (int i = 1; i <= PAGES; i++) begin
      int p;
      p = (cur + i) % PAGES;
      if (v[p[PW-1:0]]) return p;
    end
    return cur;
  endfunction

  task automatic model_step();
    bit ovl, chg;
    int nv, pp;
    if (rst) begin
      m_hold = HOLD_MAX; m_dwell = 0; m_blink = 0; m_page = 0;
      m_disp = blank_all; m_wq = watch;
      return;
    end
    ovl = (m_hold != 0);
    chg = (watch != m_wq);
    nv  = next_valid(m_page, page_valid);
    pp  = m_page;
    for (int d = 0; d < DIGITS; d++) begin
      if (ovl) m_disp[d[1:0]] = ovl_dat[d[1:0]];
      else if (!page_valid[pp[PW-1:0]]) m_disp[d[1:0]] = 6'h10;
      else if (blink_mask[d[1:0]] && m_blink >= BLINK_N / 2) m_disp[d[1:0]] = 6'h10;
      else m_disp[d[1:0]] = pg[pp[PW-1:0]][d[1:0]];
    end
    if (next_page) begin
      m_page = nv; m_dwell = 0;
    end else if (auto_rotate) begin
      if (!ovl) begin
        if (m_dwell == DWELL_MAX) begin m_page = nv; m_dwell = 0; end
        else m_dwell++;
      end
    end else if (page_valid[page_sel]) begin
      m_page = int'(page_sel);
    end
    if (chg || retrigger) m_hold = HOLD_MAX;
    else if (m_hold > 0) m_hold--;
    m_blink = (m_blink + 1) % BLINK_N;
    m_wq = watch;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    chk("display", 32'(display), 32'(m_disp));
    chk("cur_page", 32'(cur_page), 32'(m_page));
    chk("overlay_active", 32'(overlay_active), 32'(m_hold != 0));
    @(negedge clk);
  endtask

  initial begin
    int cnt, last_pg, ntick, saved;
    int seq_pg[$], seq_t[$];
    blank_all = {DIGITS{6'h10}};
    for (int p = 0; p < PAGES; p++)
      for (int d = 0; d < DIGITS; d++)
        pg[p[1:0]][d[1:0]] = 6'($urandom_range(0, 15));
    for (int d = 0; d < DIGITS; d++) ovl_dat[d[1:0]] = 6'($urandom_range(18, 40));
    rst = 1'b1; page_valid = 4'b1111; blink_mask = '0; watch = 5'h03;
    retrigger = 1'b0; auto_rotate = 1'b0; page_sel = '0; next_page = 1'b0;

    // Reset and power-on banner
    tick(); tick();
    chk("reset_display", 32'(display), 32'(blank_all));
    cnt = int'(overlay_active);
    rst = 1'b0;
    repeat (20) begin tick(); cnt += int'(overlay_active); end
    chk("banner_len", 32'(cnt), 32'd15);
    chk("page0_shown", 32'(display), 32'(pg[0]));

    // Watch change, then a second change extending the overlay
    watch = 5'h04; tick();
    tick();
    chk("overlay_shown", 32'(display), 32'(ovl_dat));
    repeat (3) tick();
    watch = 5'h05;
    cnt = 0;
    repeat (24) begin tick(); cnt += int'(overlay_active); end
    chk("extend_len", 32'(cnt), 32'd15);

    // Auto rotation over 4'b1011
    auto_rotate = 1'b1; page_valid = 4'b1011;
    last_pg = int'(cur_page); ntick = 0;
    repeat (26) begin
      tick(); ntick++;
      if (int'(cur_page) != last_pg) begin
        seq_pg.push_back(int'(cur_page)); seq_t.push_back(ntick);
        last_pg = int'(cur_page);
      end
    end
    chk("rot_count", 32'(seq_pg.size()), 32'd3);
    if (seq_pg.size() == 3) begin
      chk("rot_seq", 32'({seq_pg[0][3:0], seq_pg[1][3:0], seq_pg[2][3:0]}), 32'h130);
      chk("rot_dwell", 32'(seq_t[1] - seq_t[0]), 32'd8);
    end
    retrigger = 1'b1; tick(); retrigger = 1'b0;
    saved = int'(cur_page);
    repeat (12) tick();
    chk("dwell_frozen", 32'(cur_page), 32'(saved));
    repeat (14) tick();

    // Manual selection rules
    auto_rotate = 1'b0; page_sel = 2'd2;
    saved = int'(cur_page);
    tick();
    chk("sel_invalid_hold", 32'(cur_page), 32'(saved));
    page_valid = 4'b1111; tick();
    chk("sel_valid", 32'(cur_page), 32'd2);
    page_valid = 4'b0100; next_page = 1'b1; tick(); next_page = 1'b0;
    chk("next_only_self", 32'(cur_page), 32'd2);

    // Blinking, then overlay suppresses blink
    page_valid = 4'b1111; page_sel = 2'd1; blink_mask = 4'b0101;
    repeat (10) tick();
    retrigger = 1'b1; tick(); retrigger = 1'b0;
    repeat (16) tick();

    // No valid pages, then reset mid-rotation
    page_valid = '0;
    repeat (3) tick();
    chk("all_invalid_blank", 32'(display), 32'(blank_all));
    page_valid = 4'b1111; auto_rotate = 1'b1; blink_mask = '0;
    repeat (12) tick();
    rst = 1'b1; tick(); rst = 1'b0;
    chk("midreset_display", 32'(display), 32'(blank_all));
    chk("midreset_page", 32'(cur_page), 32'd0);
    chk("midreset_overlay", 32'(overlay_active), 32'd1);

    // Random traffic
    repeat (300) begin
      page_valid = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'b1111 ^ 4'(1 << $urandom_range(0, 3));
      next_page  = ($urandom_range(0, 9) == 0);
      retrigger  = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 24) == 0) watch = 5'($urandom);
      if ($urandom_range(0, 49) == 0) auto_rotate = ~auto_rotate;
      page_sel   = 2'($urandom);
      blink_mask = 4'($urandom);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
